// File: rtl/mod_74x32_acc.sv
// WIDTH-bit bank of 2-input OR gates, registered, with sticky-accumulate mode and ANY/RISE flags.
// Latency 1 cycle, or 2 with MOD_74X32_ACC_PIPE_EN defined (adds an input register stage).
// No backpressure: EN=0 holds Y, otherwise Y updates on every CLK edge.
module mod_74x32_acc #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             MR_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             EN,
    input  logic             MODE,
    input  logic [WIDTH-1:0] CLR,
    output logic [WIDTH-1:0] Y,
    output logic             ANY,
    output logic             RISE
);

    logic [WIDTH-1:0] a_s, b_s, clr_s;
    logic             en_s, mode_s;

`ifdef MOD_74X32_ACC_PIPE_EN
    logic [WIDTH-1:0] a_q, b_q, clr_q;
    logic             en_q, mode_q;

    always_ff @(posedge CLK) begin
        if (!MR_n) begin
            a_q    <= '0;
            b_q    <= '0;
            clr_q  <= '0;
            en_q   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            a_q    <= A;
            b_q    <= B;
            clr_q  <= CLR;
            en_q   <= EN;
            mode_q <= MODE;
        end
    end

    assign a_s    = a_q;
    assign b_s    = b_q;
    assign clr_s  = clr_q;
    assign en_s   = en_q;
    assign mode_s = mode_q;
`else
    assign a_s    = A;
    assign b_s    = B;
    assign clr_s  = CLR;
    assign en_s   = EN;
    assign mode_s = MODE;
`endif

    logic [WIDTH-1:0] y_q, y_d;
    logic             rise_q, rise_d;

    // Clear is applied before set so a same-cycle clear/set leaves the bit at 1.
    always_comb begin
        y_d = y_q;
        if (en_s) begin
            if (mode_s) begin
                y_d = (y_q & ~clr_s) | a_s | b_s;
            end else begin
                y_d = a_s | b_s;
            end
        end
        rise_d = (|y_d) & ~(|y_q);
    end

    always_ff @(posedge CLK) begin
        if (!MR_n) begin
            y_q    <= '0;
            rise_q <= 1'b0;
        end else begin
            y_q    <= y_d;
            rise_q <= rise_d;
        end
    end

    assign Y    = y_q;
    assign ANY  = |y_q;
    assign RISE = rise_q;

endmodule

// File: tb/tb_mod_74x32_acc.sv
// Self-checking bench for mod_74x32_acc (WIDTH=4): directed test-plan cases plus randomized traffic.
module tb_mod_74x32_acc;

    logic       CLK = 1'b0;
    logic       MR_n = 1'b0;
    logic [3:0] A = '0, B = '0, CLR = '0;
    logic       EN = 1'b0, MODE = 1'b0;
    logic [3:0] Y;
    logic       ANY, RISE;

    int errors = 0;
    int checks = 0;

    // Reference state
    logic [3:0] m_y = '0;
    logic       m_rise = 1'b0;
    logic [3:0] p_a = '0, p_b = '0, p_clr = '0;
    logic       p_en = 1'b0, p_mode = 1'b0;

    mod_74x32_acc #(.WIDTH(4)) dut (
        .CLK(CLK), .MR_n(MR_n), .A(A), .B(B), .EN(EN), .MODE(MODE),
        .CLR(CLR), .Y(Y), .ANY(ANY), .RISE(RISE)
    );

    always #5 CLK = ~CLK;

    // Drive one cycle of inputs, advance the reference across the edge, sample 1 time unit later.
    task automatic cycle(input logic mr, input logic [3:0] a, input logic [3:0] b,
                         input logic en, input logic mode, input logic [3:0] clr);
        logic [3:0] ea, eb, eclr, old_y;
        logic       een, emode;
        MR_n = mr; A = a; B = b; EN = en; MODE = mode; CLR = clr;
        @(posedge CLK);
`ifdef MOD_74X32_ACC_PIPE_EN
        ea = p_a; eb = p_b; eclr = p_clr; een = p_en; emode = p_mode;
        if (mr) begin
            p_a = a; p_b = b; p_clr = clr; p_en = en; p_mode = mode;
        end else begin
            p_a = '0; p_b = '0; p_clr = '0; p_en = 1'b0; p_mode = 1'b0;
        end
`else
        ea = a; eb = b; eclr = clr; een = en; emode = mode;
`endif
        old_y = m_y;
        if (!mr) begin
            m_y = '0;
            m_rise = 1'b0;
        end else begin
            if (een) m_y = emode ? ((m_y & ~eclr) | ea | eb) : (ea | eb);
            m_rise = (m_y != 0) && (old_y == 0);
        end
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 4'b0000);
        checks++; if (Y !== 4'b0000) begin errors++; $display("FAIL reset_y got=%b exp=0000", Y); end
        checks++; if (ANY !== 1'b0) begin errors++; $display("FAIL reset_any got=%b exp=0", ANY); end
        checks++; if (RISE !== 1'b0) begin errors++; $display("FAIL reset_rise got=%b exp=0", RISE); end
    endtask

    task automatic test_or_table;
        cycle(1'b1, 4'b1100, 4'b1010, 1'b1, 1'b0, 4'b0000);
        checks++; if (Y !== m_y) begin errors++; $display("FAIL or_1110 got=%b exp=%b", Y, m_y); end
`ifdef MOD_74X32_ACC_PIPE_EN
        checks++; if (Y !== 4'b0000) begin errors++; $display("FAIL pipe_first_edge got=%b exp=0000", Y); end
`else
        checks++; if (Y !== 4'b1110) begin errors++; $display("FAIL or_1110_const got=%b exp=1110", Y); end
        checks++; if (RISE !== 1'b1) begin errors++; $display("FAIL or_rise got=%b exp=1", RISE); end
`endif
        cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b0, 4'b1111);
        checks++; if (Y !== m_y) begin errors++; $display("FAIL or_zero got=%b exp=%b", Y, m_y); end
`ifdef MOD_74X32_ACC_PIPE_EN
        checks++; if (Y !== 4'b1110) begin errors++; $display("FAIL pipe_second_edge got=%b exp=1110", Y); end
`endif
        cycle(1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 4'b1111);
        cycle(1'b1, 4'b0011, 4'b0000, 1'b1, 1'b0, 4'b1111);
        checks++; if (Y !== 4'b0011) begin errors++; $display("FAIL or_clr_ignored got=%b exp=0011", Y); end
    endtask

    task automatic test_accumulate;
        cycle(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'b0000);
        cycle(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0000);
        checks++; if (RISE !== m_rise) begin errors++; $display("FAIL acc_rise1 got=%b exp=%b", RISE, m_rise); end
        cycle(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b1, 4'b0000);
        checks++; if (RISE !== m_rise) begin errors++; $display("FAIL acc_rise2 got=%b exp=%b", RISE, m_rise); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000);
            checks++; if (Y !== 4'b0101) begin errors++; $display("FAIL acc_hold%0d got=%b exp=0101", i, Y); end
            checks++; if (RISE !== 1'b0) begin errors++; $display("FAIL acc_norise%0d got=%b exp=0", i, RISE); end
        end
    endtask

    task automatic test_collision;
        cycle(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0101);
        cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000);
        checks++; if (Y !== 4'b0001) begin errors++; $display("FAIL coll_set_wins got=%b exp=0001", Y); end
        checks++; if (Y !== m_y) begin errors++; $display("FAIL coll_model got=%b exp=%b", Y, m_y); end
        cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b1111);
        cycle(1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 4'b0000);
        checks++; if (Y !== 4'b0000) begin errors++; $display("FAIL coll_clear_all got=%b exp=0000", Y); end
        checks++; if (ANY !== 1'b0) begin errors++; $display("FAIL coll_any got=%b exp=0", ANY); end
    endtask

    task automatic test_enable_hold;
        cycle(1'b1, 4'b0011, 4'b0000, 1'b1, 1'b1, 4'b1111);
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000);
        checks++; if (Y !== 4'b0011) begin errors++; $display("FAIL hold_setup got=%b exp=0011", Y); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'b1100, 4'b0000, 1'b0, 1'b1, 4'b0000);
            checks++; if (Y !== m_y) begin errors++; $display("FAIL hold%0d got=%b exp=%b", i, Y, m_y); end
        end
        checks++; if (Y !== 4'b0011) begin errors++; $display("FAIL hold_const got=%b exp=0011", Y); end
        cycle(1'b1, 4'b1100, 4'b0000, 1'b1, 1'b1, 4'b0000);
        cycle(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'b0000);
        checks++; if (Y !== 4'b1111) begin errors++; $display("FAIL hold_release got=%b exp=1111", Y); end
    endtask

    task automatic test_reset_mid;
        cycle(1'b1, 4'b1010, 4'b0000, 1'b1, 1'b1, 4'b1111);
        cycle(1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0000);
        checks++; if (Y !== 4'b0000) begin errors++; $display("FAIL mid_reset_y got=%b exp=0000", Y); end
        cycle(1'b1, 4'b0001, 4'b0000, 1'b1, 1'b1, 4'b0000);
        checks++; if (Y !== m_y) begin errors++; $display("FAIL mid_release_y got=%b exp=%b", Y, m_y); end
        checks++; if (RISE !== m_rise) begin errors++; $display("FAIL mid_release_rise got=%b exp=%b", RISE, m_rise); end
`ifndef MOD_74X32_ACC_PIPE_EN
        checks++; if (Y !== 4'b0001 || RISE !== 1'b1) begin errors++; $display("FAIL mid_release_const got=%b/%b exp=0001/1", Y, RISE); end
`endif
    endtask

    task automatic test_random;
        logic [3:0] ra, rb, rc;
        logic       rmr, ren, rmode;
        for (int i = 0; i < 400; i++) begin
            ra = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rc = 4'($urandom_range(0, 15));
            rmr = ($urandom_range(0, 29) != 0);
            ren = ($urandom_range(0, 3) != 0);
            rmode = ($urandom_range(0, 2) != 0);
            cycle(rmr, ra, rb, ren, rmode, rc);
            checks++; if (Y !== m_y) begin errors++; $display("FAIL rand_y[%0d] got=%b exp=%b", i, Y, m_y); end
            checks++; if (ANY !== (m_y != 0)) begin errors++; $display("FAIL rand_any[%0d] got=%b exp=%b", i, ANY, (m_y != 0)); end
            checks++; if (RISE !== m_rise) begin errors++; $display("FAIL rand_rise[%0d] got=%b exp=%b", i, RISE, m_rise); end
        end
    endtask

    initial begin
        #1;
        test_reset;
        test_or_table;
        test_accumulate;
        test_collision;
        test_enable_hold;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
